// File: rtl/fetch_pkg.sv
// Shared types and widths for the RV32I instruction fetch front end.
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, a single-entry
// output buffer toward decode, and redirect handling with squash of in-flight data.
//
// state  | meaning
// F_REQ  | request pending on imem at address pc
// F_WAIT | request accepted, waiting for the response (drop=1: discard it)
// F_HOLD | instruction buffered, presented to decode until accepted
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misaligned
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            drop, drop_next;
    logic            buf_load;
    logic [XLEN-1:0] target;

    assign target = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop;
        buf_load   = 1'b0;
        case (state)
            F_REQ: begin
                if (imem_req_ready) begin
                    state_next = F_WAIT;
                    drop_next  = redirect_valid;
                end
            end
            F_WAIT: begin
                if (imem_rsp_valid) begin
                    drop_next = 1'b0;
                    if (drop || redirect_valid) begin
                        state_next = F_REQ;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = F_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            F_HOLD: begin
                if (redirect_valid) begin
                    state_next = F_REQ;
                end else if (inst_ready) begin
                    pc_next    = pc + XLEN'(INST_BYTES);
                    state_next = F_REQ;
                end
            end
            default: begin
                state_next = F_REQ;
                drop_next  = 1'b0;
            end
        endcase
        // A redirect always wins over sequential advance, including a consumed F_HOLD
        if (redirect_valid) begin
            pc_next = target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= F_REQ;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            misaligned <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drop  <= drop_next;
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misaligned <= 1'b1;
            end
            if (buf_load) begin
                inst_data <= imem_rsp_data;
                inst_pc   <= pc;
            end
        end
    end

    assign imem_req_valid = (state == F_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == F_HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model,
// directed scenarios followed by randomized imem/decode/redirect traffic.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misaligned;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    // reference model: flags for "request outstanding", "outstanding is stale", "buffer full"
    logic [31:0] m_pc, m_data, m_ipc;
    bit          m_wait, m_stale, m_have, m_mis;

    // memory responder
    bit          mem_busy;
    int          mem_left;
    logic [31:0] mem_addr;
    int          lat = 1;

    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] deliv_pc[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_data = '0; m_ipc = '0;
        m_wait = 0; m_stale = 0; m_have = 0; m_mis = 0;
        mem_busy = 0; mem_left = 0; mem_addr = '0;
        imem_rsp_valid = 1'b0;
    endtask

    task automatic model_update();
        bit          acc, rsp;
        logic [31:0] tgt;
        cyc++;
        if (rst) return;
        acc = !m_wait && !m_have && imem_req_ready;
        rsp = m_wait && imem_rsp_valid;
        tgt = {redirect_pc[31:2], 2'b00};
        if (acc) begin
            acc_addr.push_back(m_pc);
            acc_cyc.push_back(cyc);
        end
        if (m_have && inst_ready) deliv_pc.push_back(m_ipc);
        if (imem_rsp_valid) mem_busy = 0;
        if (acc) begin
            mem_busy = 1; mem_left = lat; mem_addr = m_pc;
        end
        if (m_have) begin
            if (redirect_valid) begin
                m_have = 0; m_pc = tgt;
            end else if (inst_ready) begin
                m_have = 0; m_pc = m_pc + 32'd4;
            end
        end else if (m_wait) begin
            if (rsp) begin
                m_wait = 0;
                if (!m_stale && !redirect_valid) begin
                    m_have = 1; m_data = imem_rsp_data; m_ipc = m_pc;
                end
                m_stale = 0;
            end else if (redirect_valid) begin
                m_stale = 1;
            end
            if (redirect_valid) m_pc = tgt;
        end else begin
            if (acc) begin
                m_wait = 1; m_stale = redirect_valid;
            end
            if (redirect_valid) m_pc = tgt;
        end
        if (redirect_valid && redirect_pc[1:0] != 2'b00) m_mis = 1;
    endtask

    task automatic drive_mem();
        if (mem_busy && mem_left <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (mem_busy && mem_left > 0) mem_left--;
    endtask

    // called at a negedge with inputs already set; returns at the following negedge
    task automatic tick();
        drive_mem();
        @(posedge clk);
        model_update();
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("req_valid", {31'd0, imem_req_valid}, {31'd0, !m_wait && !m_have});
            check("req_addr", imem_req_addr, m_pc);
            check("inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
            check("inst_data", inst_data, m_data);
            check("inst_pc", inst_pc, m_ipc);
            check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        end
    end

    initial begin
        int n, na, nd;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        do_reset();

        // back-to-back fetch with ready memory and decode
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        acc_addr.delete(); acc_cyc.delete(); deliv_pc.delete();
        repeat (12) tick();
        check("seq_count_ok", {31'd0, acc_addr.size() >= 3}, 32'd1);
        if (acc_addr.size() >= 3) begin
            check("seq_addr0", acc_addr[0], 32'h0000_1000);
            check("seq_addr1", acc_addr[1], 32'h0000_1004);
            check("seq_addr2", acc_addr[2], 32'h0000_1008);
            check("seq_gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
            check("seq_gap12", acc_cyc[2] - acc_cyc[1], 32'd3);
        end
        check("deliv_count_ok", {31'd0, deliv_pc.size() >= 1}, 32'd1);
        if (deliv_pc.size() >= 1) check("deliv_pc0", deliv_pc[0], 32'h0000_1000);

        // decode stall for 5 cycles
        do_reset();
        inst_ready = 1'b0;
        for (int k = 0; k < 20 && !m_have; k++) tick();
        check("stall_reached", {31'd0, m_have}, 32'd1);
        n = acc_addr.size();
        repeat (5) begin
            tick();
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_pc", inst_pc, 32'h0000_1000);
        end
        check("stall_acc_count", acc_addr.size(), n);
        inst_ready = 1'b1;

        // redirect on the acceptance cycle of 0x1004
        for (int k = 0; k < 20 && !(!m_wait && !m_have && m_pc == 32'h1004); k++) tick();
        check("redir_acc_reached", m_pc, 32'h0000_1004);
        nd = deliv_pc.size();
        na = acc_addr.size();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        tick();
        check("redir_acc_took", acc_addr.size(), na + 1);
        na = acc_addr.size();
        for (int k = 0; k < 20 && acc_addr.size() == na; k++) tick();
        check("redir_acc_next", acc_addr[$], 32'h0000_2000);

        // redirect while holding, decode ready the same cycle
        for (int k = 0; k < 20 && !m_have; k++) tick();
        check("hold_reached", {31'd0, m_have}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
        tick();
        check("hold_redir_ivalid", {31'd0, inst_valid}, 32'd0);
        check("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);
        check("hold_redir_addr", imem_req_addr, 32'h0000_3000);
        check("squash_deliv_cnt", deliv_pc.size(), nd + 1);
        check("squash_deliv_pc", deliv_pc[$], 32'h0000_2000);

        // misaligned redirect target
        imem_req_ready = 1'b0;
        for (int k = 0; k < 20 && (m_wait || m_have); k++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4002;
        tick();
        check("mis_addr", imem_req_addr, 32'h0000_4000);
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        imem_req_ready = 1'b1;
        na = acc_addr.size();
        repeat (20) tick();
        check("mis_progress", {31'd0, acc_addr.size() > na + 3}, 32'd1);
        check("mis_sticky", {31'd0, misaligned}, 32'd1);

        // pc wrap at the top of the address space
        imem_req_ready = 1'b0;
        for (int k = 0; k < 20 && (m_wait || m_have); k++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        imem_req_ready = 1'b1;
        nd = deliv_pc.size();
        for (int k = 0; k < 20 && deliv_pc.size() == nd; k++) tick();
        check("wrap_deliv", deliv_pc[$], 32'hFFFF_FFFC);
        na = acc_addr.size();
        for (int k = 0; k < 20 && acc_addr.size() == na; k++) tick();
        check("wrap_next_addr", acc_addr[$], 32'h0000_0000);

        // reset while waiting on a slow response
        lat = 3;
        for (int k = 0; k < 30 && !(m_wait && mem_left >= 2); k++) tick();
        check("rstwait_reached", {31'd0, m_wait}, 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_addr", imem_req_addr, RST_PC);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            lat            = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                if ($urandom_range(0, 15) != 0) redirect_pc[1:0] = 2'b00;
            end
            if ($urandom_range(0, 799) == 0) do_reset();
            else tick();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
